// File: rtl/la_condqual.sv
// Debounce qualifier for a single-bit or-and condition term: filtered level,
// rising-edge event handshake, saturating event counter and sticky overflow.
module la_condqual #(
  parameter int CW   = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic          clear,
  input  logic          cond_in,
  input  logic [CW-1:0] thresh,
  output logic          cond_q,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [CW-1:0] evt_count,
  output logic          overflow
);

  localparam logic [0:0] ST_LOW  = 1'b0;
  localparam logic [0:0] ST_HIGH = 1'b1;
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  // PROP is an implementation tag only; it selects nothing.
  if ($bits(PROP) > 0) begin : g_prop
  end

  logic [0:0]    r_state;
  logic [CW-1:0] r_fcnt;
  logic          r_evt_valid;
  logic [CW-1:0] r_evt_count;
  logic          r_overflow;

  logic [CW-1:0] w_thr;
  logic [CW-1:0] w_fnext;
  logic          w_disagree;
  logic          w_flip;
  logic          w_rise;

  assign w_thr      = (thresh == '0) ? ONE : thresh;
  assign w_fnext    = r_fcnt + ONE;
  // A sample "disagrees" when it argues for the opposite level.
  assign w_disagree = (r_state == ST_LOW) ? cond_in : ~cond_in;
  assign w_flip     = en & w_disagree & (w_fnext >= w_thr);
  assign w_rise     = w_flip & (r_state == ST_LOW);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= ST_LOW;
      r_fcnt  <= '0;
    end else if (!en || !w_disagree) begin
      r_fcnt  <= '0;
    end else if (w_flip) begin
      r_state <= (r_state == ST_LOW) ? ST_HIGH : ST_LOW;
      r_fcnt  <= '0;
    end else begin
      r_fcnt  <= w_fnext;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset || clear) begin
      r_evt_valid <= 1'b0;
      r_evt_count <= '0;
      r_overflow  <= 1'b0;
    end else if (w_rise) begin
      if (r_evt_count != '1) r_evt_count <= r_evt_count + ONE;
      if (r_evt_valid && !evt_ready) r_overflow <= 1'b1;
      r_evt_valid <= 1'b1;
    end else if (r_evt_valid && evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign cond_q    = r_state[0];
  assign evt_valid = r_evt_valid;
  assign evt_count = r_evt_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_la_condqual.sv
// Scenario bench for la_condqual (CW=4) against a run-length reference model.
module tb_la_condqual;

  localparam int CW  = 4;
  localparam int MAX = 15;

  logic          clk = 1'b0;
  logic          nreset, en, clear, cond_in, evt_ready;
  logic [CW-1:0] thresh;
  logic          cond_q, evt_valid, overflow;
  logic [CW-1:0] evt_count;

  int n_chk = 0;
  int n_err = 0;

  // reference state
  bit m_lvl, m_valid, m_ovf;
  int m_run, m_cnt;

  always #5 clk = ~clk;

  la_condqual #(.CW(CW), .PROP("DEFAULT")) dut (
    .clk(clk), .nreset(nreset), .en(en), .clear(clear), .cond_in(cond_in),
    .thresh(thresh), .cond_q(cond_q), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_count(evt_count), .overflow(overflow)
  );

  // Advance model and DUT by one edge using the currently driven inputs.
  task automatic tick();
    int t;
    bit rise;
    t = (thresh == 0) ? 1 : int'(thresh);
    rise = 1'b0;
    if (!nreset) begin
      m_lvl = 0; m_run = 0; m_valid = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      if (!en) m_run = 0;
      else if (cond_in != m_lvl) begin
        m_run++;
        if (m_run >= t) begin
          m_lvl = cond_in; m_run = 0; rise = cond_in;
        end
      end else m_run = 0;
      if (clear) begin
        m_valid = 0; m_cnt = 0; m_ovf = 0;
      end else if (rise) begin
        if (m_cnt < MAX) m_cnt++;
        if (m_valid && !evt_ready) m_ovf = 1;
        m_valid = 1;
      end else if (m_valid && evt_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 0; en = 0; clear = 0; cond_in = 0; evt_ready = 0; thresh = 0;
    tick(); tick();
    n_chk++;
    if ({cond_q, evt_valid, evt_count, overflow} !== 7'b0) begin
      n_err++;
      $display("FAIL reset got=%b required=%b", {cond_q, evt_valid, evt_count, overflow}, 7'b0);
    end
  endtask

  task automatic test_basic_rise();
    nreset = 1; en = 1; thresh = 3; cond_in = 1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) evt_ready = 1;
      tick();
      n_chk++;
      if ({cond_q, evt_valid, evt_count, overflow} !== {m_lvl, m_valid, 4'(m_cnt), m_ovf}) begin
        n_err++;
        $display("FAIL basic_model edge=%0d got=%b required=%b", i,
                 {cond_q, evt_valid, evt_count, overflow}, {m_lvl, m_valid, 4'(m_cnt), m_ovf});
      end
      if (i == 2) begin
        n_chk++;
        if (cond_q !== 1'b0) begin n_err++; $display("FAIL basic_early got=%b required=0", cond_q); end
      end
      if (i == 3) begin
        n_chk++;
        if ({cond_q, evt_valid, evt_count} !== 6'b11_0001) begin
          n_err++; $display("FAIL basic_rise got=%b required=110001", {cond_q, evt_valid, evt_count});
        end
      end
      if (i == 5) begin
        n_chk++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL basic_accept got=%b required=0", evt_valid); end
      end
    end
    evt_ready = 0;
  endtask

  task automatic test_glitch();
    bit pat_up [6] = '{1, 1, 0, 1, 1, 0};
    bit pat_dn [3] = '{0, 0, 1};
    cond_in = 0; tick(); tick(); tick();
    clear = 1; tick(); clear = 0;
    foreach (pat_up[i]) begin
      cond_in = pat_up[i]; tick();
      n_chk++;
      if ({cond_q, evt_count} !== 5'b0) begin
        n_err++; $display("FAIL glitch_up step=%0d got=%b required=00000", i, {cond_q, evt_count});
      end
    end
    cond_in = 1; tick(); tick(); tick();
    foreach (pat_dn[i]) begin
      cond_in = pat_dn[i]; tick();
      n_chk++;
      if (cond_q !== 1'b1) begin n_err++; $display("FAIL glitch_dn step=%0d got=%b required=1", i, cond_q); end
    end
  endtask

  task automatic test_overflow_sat();
    thresh = 1; evt_ready = 0; cond_in = 0; tick();
    clear = 1; tick(); clear = 0;
    for (int i = 0; i < 20; i++) begin
      cond_in = 1; tick();
      cond_in = 0; tick();
    end
    n_chk++;
    if ({evt_count, evt_valid, overflow} !== 6'b1111_11) begin
      n_err++; $display("FAIL sat got=%b required=111111", {evt_count, evt_valid, overflow});
    end
    clear = 1; tick(); clear = 0;
    n_chk++;
    if ({cond_q, evt_valid, evt_count, overflow} !== 7'b0) begin
      n_err++; $display("FAIL sat_clear got=%b required=0000000", {cond_q, evt_valid, evt_count, overflow});
    end
  endtask

  task automatic test_simultaneous();
    thresh = 1;
    cond_in = 1; tick();
    cond_in = 0; tick();
    cond_in = 1; evt_ready = 1; tick(); evt_ready = 0;
    n_chk++;
    if ({evt_valid, overflow, evt_count} !== 6'b10_0010) begin
      n_err++; $display("FAIL rise_with_ready got=%b required=100010", {evt_valid, overflow, evt_count});
    end
    cond_in = 0; tick();
    cond_in = 1; clear = 1; tick(); clear = 0;
    n_chk++;
    if ({cond_q, evt_valid, evt_count, overflow} !== 7'b1000000) begin
      n_err++; $display("FAIL rise_with_clear got=%b required=1000000", {cond_q, evt_valid, evt_count, overflow});
    end
  endtask

  task automatic test_thresh_zero_en();
    bit prev;
    thresh = 0;
    for (int i = 0; i < 12; i++) begin
      prev = 1'($urandom_range(0, 1));
      cond_in = prev; tick();
      n_chk++;
      if (cond_q !== prev) begin n_err++; $display("FAIL t0_follow step=%0d got=%b required=%b", i, cond_q, prev); end
    end
    cond_in = 0; tick();
    thresh = 4; cond_in = 1;
    tick(); tick();
    en = 0; tick(); en = 1;
    tick(); tick(); tick();
    n_chk++;
    if (cond_q !== 1'b0) begin n_err++; $display("FAIL en_restart_early got=%b required=0", cond_q); end
    tick();
    n_chk++;
    if (cond_q !== 1'b1) begin n_err++; $display("FAIL en_restart got=%b required=1", cond_q); end
  endtask

  task automatic test_reset_mid();
    thresh = 1; cond_in = 0; tick();
    clear = 1; tick(); clear = 0;
    cond_in = 1; tick();
    cond_in = 0; tick();
    thresh = 5; cond_in = 1;
    tick(); tick(); tick();
    n_chk++;
    if ({cond_q, evt_valid} !== 2'b01) begin
      n_err++; $display("FAIL mid_pending got=%b required=01", {cond_q, evt_valid});
    end
    nreset = 0; tick(); nreset = 1;
    n_chk++;
    if ({cond_q, evt_valid, evt_count, overflow} !== 7'b0) begin
      n_err++; $display("FAIL mid_reset got=%b required=0000000", {cond_q, evt_valid, evt_count, overflow});
    end
    tick(); tick(); tick(); tick();
    n_chk++;
    if (cond_q !== 1'b0) begin n_err++; $display("FAIL mid_requal_early got=%b required=0", cond_q); end
    tick();
    n_chk++;
    if ({cond_q, evt_count} !== 5'b1_0001) begin
      n_err++; $display("FAIL mid_requal got=%b required=10001", {cond_q, evt_count});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      nreset    = ($urandom_range(0, 99) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      en        = ($urandom_range(0, 9) != 0);
      evt_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) thresh = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) cond_in = ~cond_in;
      tick();
      n_chk++;
      if ({cond_q, evt_valid, evt_count, overflow} !== {m_lvl, m_valid, 4'(m_cnt), m_ovf}) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%b required=%b", i,
                 {cond_q, evt_valid, evt_count, overflow}, {m_lvl, m_valid, 4'(m_cnt), m_ovf});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rise();
    test_glitch();
    test_overflow_sat();
    test_simultaneous();
    test_thresh_zero_en();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/la_condqual.md
Name: la_condqual

Overview:
- Sequential qualifier that consumes the single-bit output of an or-and condition gate, typically a stdlib oa33 term combining two 3-input request groups.
- Debounces the raw condition: it must hold for a programmable number of consecutive cycles before it is accepted.
- Each qualified rising edge is captured as an event and presented on a valid/ready handshake.
- Qualified events are counted in a saturating counter; a lost (unacknowledged) event raises a sticky overflow flag.

Parameters:
- CW, 8, width of the threshold input and the event counter.
- PROP, "DEFAULT", implementation property string, passed through with no functional effect.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nreset  input  1  synchronous active-low reset.
- en  input  1  qualifier enable.
- clear  input  1  synchronous clear of the event state (evt_valid, evt_count, overflow).
- cond_in  input  1  raw condition from the upstream or-and gate output.
- thresh  input  CW  number of consecutive agreeing samples needed to change the filtered level (0 is treated as 1).
- cond_q  output  1  filtered (qualified) condition level.
- evt_valid  output  1  qualified rising-edge event pending.
- evt_ready  input  1  consumer accepts the pending event.
- evt_count  output  CW  saturating count of qualified rising edges.
- overflow  output  1  sticky: an event arrived while one was still pending.

Behaviour:
- Reset (nreset=0 at a clock edge):
  - State goes to LOW and the filter counter to 0.
  - cond_q=0, evt_valid=0, evt_count=0, overflow=0.
  - Reset has priority over every other input.
- Mid-operation reset abandons any partial qualification and drops a pending event without setting overflow.
- Effective threshold T = (thresh==0) ? 1 : thresh. thresh is sampled every cycle, so a change takes effect on the next comparison.
- The FSM has two levels, LOW and HIGH, plus a filter counter fcnt of CW bits:
  - LOW: cond_in=1 → fcnt+1; cond_in=0 → fcnt=0. When the sample would make fcnt+1 ≥ T: go to HIGH, set fcnt=0, set cond_q=1, and fire a rise event on that same edge.
  - HIGH: cond_in=0 → fcnt+1; cond_in=1 → fcnt=0. When fcnt+1 ≥ T: go to LOW, set fcnt=0, set cond_q=0. A fall does not generate an event.
- Latency: cond_q changes on the clock edge that takes the T-th consecutive agreeing sample. With T=1 this is a plain one-register delay.
- fcnt never wraps, because it is cleared on reaching T and T ≤ 2^CW-1.
- en=0:
  - The FSM state and cond_q hold, and fcnt is forced to 0.
  - No events are generated.
  - The handshake, clear and counter hold logic still operate.
  - When en returns to 1, qualification restarts from a zero count.
- Rise event effects, applied on the firing edge:
  - evt_count increments, saturating at 2^CW-1.
  - If evt_valid=0, or evt_valid=1 with evt_ready=1 on the same edge, evt_valid becomes (or stays) 1 and overflow is unchanged.
  - If evt_valid=1 and evt_ready=0, evt_valid stays 1 and overflow is set.
- Handshake:
  - A transfer happens on any edge where evt_valid=1 and evt_ready=1. evt_valid then clears, unless a rise event fires on the same edge.
  - evt_valid stays asserted until it is accepted.
  - evt_ready while evt_valid=0 has no effect.
- clear=1:
  - Sets evt_valid=0, evt_count=0 and overflow=0.
  - Does not change cond_q, the FSM state or fcnt.
  - Takes priority over a simultaneous rise event, which is discarded and not counted.
- All outputs are driven directly from registers; there is no combinational path from input to output.

Test Plan:
- Reset then basic rise: nreset=0 for 2 cycles, then en=1, thresh=3, cond_in=1 from edge 1 → cond_q=1 and evt_valid=1 after edge 3, evt_count=1; evt_ready=1 at edge 5 → evt_valid=0 after edge 5.
- Glitch rejection: thresh=3, cond_in pattern 1,1,0,1,1,0 → cond_q stays 0 and evt_count stays 0. Then with cond_q=1, a low pattern 0,0,1 → cond_q stays 1.
- Overflow and saturation: CW=4, thresh=1, evt_ready=0, cond_in toggles 1/0 for 20 rises → evt_count=15 (saturated), evt_valid=1, overflow=1. Then clear=1 → all three are 0 and cond_q is unchanged.
- Simultaneous events:
  - Rise fires on the same edge as evt_ready=1 with evt_valid=1 → evt_valid stays 1, overflow=0, count+1.
  - clear=1 on the same edge as a rise → evt_count=0, evt_valid=0.
- Threshold zero and enable: thresh=0 → cond_q follows cond_in one cycle late. With thresh=4, drop en=0 after 2 high samples, re-enable → 4 further high samples are needed before cond_q=1.
- Reset mid-operation: thresh=5, 3 high samples and evt_valid=1 pending, then nreset=0 for one edge → all outputs are 0, and a fresh qualification needs 5 samples.
